// File: rtl/lcb_req_parser.sv
// lcb_req_parser
// Request-frame parser sitting between the UART byte receiver and the LCB
// answer transmitter. Hunts for SYNC, collects ADDR/CMD/CSUM, validates the
// checksum and the unit address, and issues a one-cycle RQ with the decoded
// command. Corrupted frames and inter-byte timeouts bump a saturating error
// counter; frames for other units are dropped silently.
//
// Build option: define LCB_BROADCAST_EN to also accept ADDR 8'h1F as a
// broadcast (RQ with is_bcast=1). Without it is_bcast is constant 0.
module lcb_req_parser #(
  parameter logic [4:0]  MY_ADDR = 5'd3,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic       clk80MHz,
  input  logic       rst,
  input  logic       val,
  input  logic [7:0] data,
  output logic       RQ,
  output logic [7:0] cmd,
  output logic       is_bcast,
  output logic       busy,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    W_ADDR = 2'd1,
    W_CMD  = 2'd2,
    W_CSUM = 2'd3
  } state_t;

  // Address as it appears on the wire (upper three bits always zero).
  localparam logic [7:0]  MY_ADDR8   = {3'b000, MY_ADDR};
  localparam logic [7:0]  BCAST_ADDR = 8'h1F;
  // Idle-counter value at which a silent line is declared dead.
  localparam logic [15:0] IDLE_LIMIT = TIMEOUT - 16'd1;

  // 8-bit wrap-around checksum over ADDR and CMD.
  function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  // Increment that sticks at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_addr;
  logic [7:0]  r_cmd_lat;
  logic [15:0] r_idle;
  logic        r_rq;
  logic [7:0]  r_cmd;
  logic        r_busy;
  logic [7:0]  r_err;

  logic        w_in_frame;
  logic        w_timeout;
  logic        w_csum_byte;
  logic        w_csum_ok;
  logic        w_unicast;
  logic        w_bcast_hit;
  logic        w_accept;
  logic        w_err_evt;

  assign w_in_frame  = (r_state != HUNT);
  // A byte on the limit cycle wins over the timeout.
  assign w_timeout   = w_in_frame && !val && (r_idle == IDLE_LIMIT);
  assign w_csum_byte = (r_state == W_CSUM) && val;
  assign w_csum_ok   = (csum8(r_addr, r_cmd_lat) == data);
  assign w_unicast   = (r_addr == MY_ADDR8);

`ifdef LCB_BROADCAST_EN
  // A unit whose own address is 1F sees those frames as unicast.
  assign w_bcast_hit = (r_addr == BCAST_ADDR) && !w_unicast;
`else
  assign w_bcast_hit = 1'b0;
`endif

  assign w_accept  = w_csum_byte && w_csum_ok && (w_unicast || w_bcast_hit);
  assign w_err_evt = (w_csum_byte && !w_csum_ok) || w_timeout;

  // State register.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; SYNC inside a frame is ordinary data (no resync).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HUNT: begin
        if (val && (data == SYNC)) w_state_nxt = W_ADDR;
      end
      W_ADDR: begin
        if (val)            w_state_nxt = W_CMD;
        else if (w_timeout) w_state_nxt = HUNT;
      end
      W_CMD: begin
        if (val)            w_state_nxt = W_CSUM;
        else if (w_timeout) w_state_nxt = HUNT;
      end
      W_CSUM: begin
        if (val || w_timeout) w_state_nxt = HUNT;
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // Idle counter: runs only between bytes of a frame, cleared on any byte.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      r_idle <= 16'd0;
    end else if (val || !w_in_frame || w_timeout) begin
      r_idle <= 16'd0;
    end else begin
      r_idle <= r_idle + 16'd1;
    end
  end

  // Capture ADDR and CMD as they arrive.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      r_addr    <= 8'h00;
      r_cmd_lat <= 8'h00;
    end else begin
      if ((r_state == W_ADDR) && val) r_addr    <= data;
      if ((r_state == W_CMD)  && val) r_cmd_lat <= data;
    end
  end

  // Registered request pulse and command hold.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      r_rq  <= 1'b0;
      r_cmd <= 8'h00;
    end else begin
      r_rq <= w_accept;
      if (w_accept) r_cmd <= r_cmd_lat;
    end
  end

  // Busy follows the state the FSM is entering, so it is aligned with RQ.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != HUNT);
    end
  end

  // Saturating error counter for checksum failures and timeouts.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      r_err <= 8'h00;
    end else if (w_err_evt) begin
      r_err <= sat_inc8(r_err);
    end
  end

`ifdef LCB_BROADCAST_EN
  logic r_bcast;

  // Broadcast flag, loaded with every accepted frame.
  always_ff @(posedge clk80MHz or negedge rst) begin
    if (!rst) begin
      r_bcast <= 1'b0;
    end else if (w_accept) begin
      r_bcast <= w_bcast_hit;
    end
  end

  assign is_bcast = r_bcast;
`else
  assign is_bcast = 1'b0;
`endif

  assign RQ      = r_rq;
  assign cmd     = r_cmd;
  assign busy    = r_busy;
  assign err_cnt = r_err;

endmodule

// File: doc/lcb_req_parser.md
# lcb_req_parser

Request-frame parser between the UART byte receiver and the LCB answer transmitter in the LCB simulator.
- Consumes the byte stream and byte-valid strobe coming from the CFM side.
- Finds request frames, checks their checksum and address, and issues a one-cycle `RQ` pulse plus the decoded command to the TX stage.
- Drops frames that are corrupted, timed out or addressed to another unit, and counts errors.

## Interface
Parameters:
- `MY_ADDR`, 5'd3: LCB unit address this simulator answers to.
- `SYNC`, 8'hA5: frame sync byte.
- `TIMEOUT`, 16'd4000: maximum idle clocks between bytes inside a frame (50 µs at 80 MHz); legal range 2..65535.

Ports:
- `clk80MHz` in 1: single system clock, 80 MHz.
- `rst` in 1: reset, asynchronous, active-low.
- `val` in 1: byte strobe from the UART receiver; each high cycle is exactly one byte.
- `data` in 8: received byte, valid when `val`=1.
- `RQ` out 1: one-cycle pulse, accepted request for this unit.
- `cmd` out 8: command byte of the last accepted frame; held until the next accepted frame.
- `is_bcast` out 1: 1 when the last accepted frame was a broadcast; updated together with `cmd`.
- `busy` out 1: high whenever the FSM is not in HUNT.
- `err_cnt` out 8: saturating count of checksum errors and timeouts.

## Operation
- Frame format: `SYNC`, `ADDR`, `CMD`, `CSUM`.
  - `CSUM` = (`ADDR` + `CMD`) mod 256, 8-bit wrap-around add.
- FSM states and transitions:
  - HUNT: a `val` with `data`==`SYNC` goes to W_ADDR. Any other byte is ignored, with no error.
  - W_ADDR: on `val`, latch `ADDR` and go to W_CMD.
  - W_CMD: on `val`, latch `CMD` and go to W_CSUM.
  - W_CSUM: on `val`, evaluate the frame and always return to HUNT.
- Frame evaluation in W_CSUM:
  - Checksum mismatch: no `RQ`; `err_cnt` +1.
  - Checksum match and `ADDR`=={3'b000, `MY_ADDR`}: `RQ` pulses; `cmd` <= `CMD`; `is_bcast` <= 0.
  - Checksum match and address mismatch: frame silently dropped; no error.
- No resync inside a frame: a byte equal to `SYNC` in W_ADDR, W_CMD or W_CSUM is treated as ordinary data.
- Idle counter:
  - Cleared on every `val` and while in HUNT.
  - Otherwise increments each clock.
  - When it reaches `TIMEOUT`-1 with `val`=0: FSM returns to HUNT, `err_cnt` +1, no `RQ`.
  - If `val` arrives in the same cycle the limit is reached, `val` wins: the byte is processed and the counter clears.
- `err_cnt` saturates at 255; further errors leave it at 255.
- Reset mid-frame discards the partial frame.

## Timing
- Values during reset:
  - `RQ`=0, `cmd`=8'h00, `is_bcast`=0, `busy`=0, `err_cnt`=0.
  - FSM in HUNT, idle counter 0.
- All outputs are registered.
- `RQ` is high exactly one cycle: the cycle after the `val` cycle that carried `CSUM`.
  - `cmd` and `is_bcast` take their new values in that same cycle.
- `err_cnt` updates in the cycle after the failing `CSUM` byte, or in the cycle after the timeout is detected.
- `busy` rises in the cycle after the `SYNC` byte. It falls in the cycle `RQ` would appear, or in the cycle after a timeout.
- Back-to-back frames are allowed: a `SYNC` byte arriving on the cycle immediately after `CSUM` is accepted.
- Minimum byte spacing is one clock.

## Configuration
- `LCB_BROADCAST_EN` defined:
  - `ADDR`==8'h1F with a correct checksum is also accepted.
  - Produces `RQ`, loads `cmd`, sets `is_bcast`=1.
  - A `MY_ADDR` of 5'h1F is treated as a normal unicast match (`is_bcast`=0).
- `LCB_BROADCAST_EN` undefined:
  - 8'h1F follows the normal address rule (dropped unless it equals `MY_ADDR`).
  - `is_bcast` is tied to 0.

## Test plan
- Good frame A5 03 10 13, `MY_ADDR`=3 -> single-cycle `RQ` one clock after the 4th `val`; `cmd`=8'h10; `err_cnt`=0; `busy` low afterwards.
- Garbage bytes 00 FF 03 then frame A5 03 10 14 (bad checksum) -> no `RQ`; `err_cnt`=1; a following A5 03 07 0A gives `RQ` with `cmd`=8'h07.
- Timeout: A5 03 then no `val` for `TIMEOUT` clocks -> HUNT, `err_cnt`=1.
  - Repeat with `val` exactly on the limit cycle -> byte accepted, no error.
- Address mismatch A5 04 10 14 -> no `RQ`, `err_cnt` unchanged. Then A5 1F 22 41:
  - With `LCB_BROADCAST_EN`: `RQ`, `cmd`=8'h22, `is_bcast`=1.
  - Without it: no `RQ`.
- 300 consecutive bad-checksum frames -> `err_cnt` stops at 255.
- Assert `rst` low after A5 03 10, release, then send 13 -> no `RQ`; a full good frame afterwards gives `RQ`.
